prog_num_stabilizer: RTL and testbench

Multi-channel successor to the single-bus program-number debouncer. It has the following stages:
- Synchronises NUM_CH independent WIDTH-bit program buses into clk.
- Requires each bus to hold one value for a run-time-programmable number of cycles.
- Then commits the value to the output.
Adds hold, grouped (all-channels-together) commit, per-channel update strobes and saturating glitch counters. Sits between the front-panel/serial program inputs and the phase-delay program decode logic.

---
 rtl/prog_num_stabilizer_pkg.sv | 15 +
 rtl/prog_ch_filter.sv | 72 +++++++
 rtl/prog_num_stabilizer.sv | 84 ++++++++
 tb/tb_prog_num_stabilizer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/prog_num_stabilizer_pkg.sv
// Shared constants and helpers for the multi-channel program-number stabilizer.
package prog_num_stabilizer_pkg;

  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_TIMER_W = 15;

  localparam bit MODE_INDEP   = 1'b0;
  localparam bit MODE_GROUPED = 1'b1;

  // LSB position of channel ch in a flat bus of w-bit channel fields
  function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned w);
    return ch * w;
  endfunction

endpackage

// File: rtl/prog_ch_filter.sv
// One channel: input synchroniser, candidate/stability timer, glitch counter, busy flag.
module prog_ch_filter
  import prog_num_stabilizer_pkg::*;
#(
  parameter int unsigned      WIDTH       = DEF_WIDTH,
  parameter int unsigned      TIMER_W     = DEF_TIMER_W,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter int unsigned      GLITCH_W    = 8,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    din,
  input  logic [TIMER_W-1:0]  wait_cycles,
  input  logic                glitch_clr,
  input  logic [WIDTH-1:0]    prog_num,
  input  logic [WIDTH-1:0]    prog_num_d_c,
  output logic [WIDTH-1:0]    cand,
  output logic                stable_c,
  output logic                busy,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  s;
  logic [WIDTH-1:0]                  cand_d;
  logic [TIMER_W-1:0]                timer;
  logic [TIMER_W-1:0]                timer_d;
  logic [GLITCH_W-1:0]               glitch_d;
  logic                              glitch_hit;

  assign s        = sync_q[SYNC_STAGES-1];
  assign stable_c = (s == cand) && (timer >= wait_cycles);

  // Candidate tracking; an abandoned candidate that was heading for commit is a glitch
  always_comb begin
    cand_d     = cand;
    timer_d    = timer;
    glitch_d   = glitch_cnt;
    glitch_hit = 1'b0;
    if (s != cand) begin
      cand_d     = s;
      timer_d    = '0;
      glitch_hit = (timer != '0) && (cand != prog_num);
    end else if (timer < wait_cycles) begin
      timer_d = timer + TIMER_W'(1);
    end
    if (glitch_clr) begin
      glitch_d = '0;
    end else if (glitch_hit && (glitch_cnt != '1)) begin
      glitch_d = glitch_cnt + GLITCH_W'(1);
    end
  end

  // busy is registered from next-state values so it tracks cand != prog_num without lag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= {SYNC_STAGES{RESET_VAL}};
      cand       <= RESET_VAL;
      timer      <= '0;
      glitch_cnt <= '0;
      busy       <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], din};
      cand       <= cand_d;
      timer      <= timer_d;
      glitch_cnt <= glitch_d;
      busy       <= (cand_d != prog_num_d_c);
    end
  end

endmodule

// File: rtl/prog_num_stabilizer.sv
// Multi-channel program-number stabilizer: per-channel filters plus commit/hold/grouping.
module prog_num_stabilizer
  import prog_num_stabilizer_pkg::*;
#(
  parameter int unsigned      NUM_CH      = 4,
  parameter int unsigned      WIDTH       = DEF_WIDTH,
  parameter int unsigned      TIMER_W     = DEF_TIMER_W,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter bit               GROUPED     = MODE_INDEP,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0,
  parameter int unsigned      GLITCH_W    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH*WIDTH-1:0]    prog_in,
  input  logic [TIMER_W-1:0]         wait_cycles,
  input  logic                       hold,
  input  logic                       glitch_clr,
  output logic [NUM_CH*WIDTH-1:0]    prog_num,
  output logic [NUM_CH-1:0]          update,
  output logic [NUM_CH-1:0]          busy,
  output logic [NUM_CH*GLITCH_W-1:0] glitch_cnt
);

  logic [NUM_CH-1:0][WIDTH-1:0] cand;
  logic [NUM_CH-1:0]            stable;
  logic [NUM_CH-1:0]            pend;
  logic [NUM_CH-1:0]            commit;
  logic [NUM_CH*WIDTH-1:0]      prog_num_d;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    prog_ch_filter #(
      .WIDTH       (WIDTH),
      .TIMER_W     (TIMER_W),
      .SYNC_STAGES (SYNC_STAGES),
      .GLITCH_W    (GLITCH_W),
      .RESET_VAL   (RESET_VAL)
    ) u_filter (
      .clk          (clk),
      .rst_n        (rst_n),
      .din          (prog_in[ch_lsb(c, WIDTH) +: WIDTH]),
      .wait_cycles  (wait_cycles),
      .glitch_clr   (glitch_clr),
      .prog_num     (prog_num[ch_lsb(c, WIDTH) +: WIDTH]),
      .prog_num_d_c (prog_num_d[ch_lsb(c, WIDTH) +: WIDTH]),
      .cand         (cand[c]),
      .stable_c     (stable[c]),
      .busy         (busy[c]),
      .glitch_cnt   (glitch_cnt[ch_lsb(c, GLITCH_W) +: GLITCH_W])
    );

    assign pend[c] = (cand[c] != prog_num[ch_lsb(c, WIDTH) +: WIDTH]);
  end

  // Grouped mode fires only when every channel is settled; only changed channels pulse
  always_comb begin
    commit = '0;
    if (!hold) begin
      if (GROUPED == MODE_GROUPED) begin
        if ((&stable) && (|pend)) commit = pend;
      end else begin
        commit = stable & pend;
      end
    end
  end

  always_comb begin
    prog_num_d = prog_num;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (commit[c]) prog_num_d[ch_lsb(c, WIDTH) +: WIDTH] = cand[c];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prog_num <= {NUM_CH{RESET_VAL}};
      update   <= '0;
    end else begin
      prog_num <= prog_num_d;
      update   <= commit;
    end
  end

endmodule

// File: tb/tb_prog_num_stabilizer.sv
// Directed self-checking bench: independent-mode DUT plus a grouped-mode DUT on shared controls.
module tb_prog_num_stabilizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] prog_in;
  logic [31:0] prog_in_g;
  logic [14:0] wait_cycles;
  logic        hold;
  logic        glitch_clr;
  logic [31:0] prog_num, prog_num_g;
  logic [3:0]  update, update_g;
  logic [3:0]  busy, busy_g;
  logic [31:0] glitch_cnt, glitch_g;

  int vectors     = 0;
  int miscompares = 0;
  logic [3:0] upd_seen;
  logic [3:0] updg_seen;

  always #5 clk = ~clk;

  prog_num_stabilizer dut (
    .clk(clk), .rst_n(rst_n), .prog_in(prog_in), .wait_cycles(wait_cycles),
    .hold(hold), .glitch_clr(glitch_clr), .prog_num(prog_num), .update(update),
    .busy(busy), .glitch_cnt(glitch_cnt)
  );

  prog_num_stabilizer #(.GROUPED(1'b1)) dut_g (
    .clk(clk), .rst_n(rst_n), .prog_in(prog_in_g), .wait_cycles(wait_cycles),
    .hold(hold), .glitch_clr(glitch_clr), .prog_num(prog_num_g), .update(update_g),
    .busy(busy_g), .glitch_cnt(glitch_g)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      upd_seen  = upd_seen | update;
      updg_seen = updg_seen | update_g;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] chv(input logic [31:0] v, input int c);
    logic [31:0] t;
    t = v >> (c * 8);
    return t[7:0];
  endfunction

  initial begin
    rst_n = 1'b0; prog_in = '0; prog_in_g = '0;
    wait_cycles = 15'd10; hold = 1'b0; glitch_clr = 1'b0;
    upd_seen = '0; updg_seen = '0;

    // Reset state
    tick(2);
    chk("rst_prog_num", prog_num, 32'h0);
    chk("rst_update", 32'(update), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_glitch", glitch_cnt, 32'h0);
    chk("rst_prog_num_g", prog_num_g, 32'h0);
    rst_n = 1'b1;
    tick(2);

    // Clean step on ch0, W=10: commit 2+10+2 = 14 edges after the step
    prog_in[7:0] = 8'h5A;
    upd_seen = '0;
    tick(13);
    chk("step_no_upd_before", 32'(upd_seen), 32'h0);
    chk("step_prog_before", 32'(chv(prog_num, 0)), 32'h00);
    chk("step_busy_pending", 32'(busy), 32'h1);
    tick(1);
    chk("step_prog_commit", 32'(chv(prog_num, 0)), 32'h5A);
    chk("step_update_pulse", 32'(update), 32'h1);
    chk("step_busy_clear", 32'(busy), 32'h0);
    tick(1);
    chk("step_update_single", 32'(update), 32'h0);

    // Glitch on ch1: 0x33 for 5 cycles then back to 0x00
    upd_seen = '0;
    prog_in[15:8] = 8'h33;
    tick(5);
    prog_in[15:8] = 8'h00;
    tick(20);
    chk("glitch_no_upd", 32'(upd_seen), 32'h0);
    chk("glitch_prog_kept", 32'(chv(prog_num, 1)), 32'h00);
    chk("glitch_count", glitch_cnt, 32'h0000_0100);
    chk("glitch_busy", 32'(busy), 32'h0);

    // Grouped mode: ch0 settles at 0x11 while ch3 bounces; nothing commits
    updg_seen = '0;
    prog_in_g[7:0] = 8'h11;
    for (int k = 0; k < 10; k++) begin
      prog_in_g[31:24] = (k % 2 == 0) ? 8'h40 : 8'h41;
      tick(3);
    end
    chk("grp_no_upd_bounce", 32'(updg_seen), 32'h0);
    chk("grp_prog_bounce", prog_num_g, 32'h0);
    prog_in_g[31:24] = 8'h44;
    tick(13);
    chk("grp_no_upd_before", 32'(updg_seen), 32'h0);
    chk("grp_prog_before", prog_num_g, 32'h0);
    tick(1);
    chk("grp_prog_commit", prog_num_g, 32'h4400_0011);
    chk("grp_update_mask", 32'(update_g), 32'h9);
    chk("grp_glitch_ch3", glitch_g, 32'h0A00_0000);
    chk("grp_busy", 32'(busy_g), 32'h0);

    // W=0: ch2 toggles every 4 cycles, each value lands after 4 edges
    wait_cycles = 15'd0;
    tick(2);
    begin
      logic [7:0] vals [4];
      logic [7:0] prev;
      vals[0] = 8'h01; vals[1] = 8'h02; vals[2] = 8'h01; vals[3] = 8'h02;
      prev = 8'h00;
      for (int k = 0; k < 4; k++) begin
        prog_in[23:16] = vals[k];
        tick(3);
        chk("w0_prog_before", 32'(chv(prog_num, 2)), 32'(prev));
        tick(1);
        chk("w0_prog_commit", 32'(chv(prog_num, 2)), 32'(vals[k]));
        chk("w0_update", 32'(update), 32'h4);
        prev = vals[k];
      end
    end
    tick(1);
    chk("w0_update_single", 32'(update), 32'h0);

    // Hold: ch0 goes stable at 0x7F but must wait for release
    wait_cycles = 15'd10;
    hold = 1'b1;
    tick(2);
    upd_seen = '0;
    prog_in[7:0] = 8'h7F;
    tick(20);
    chk("hold_no_upd", 32'(upd_seen), 32'h0);
    chk("hold_prog_frozen", 32'(chv(prog_num, 0)), 32'h5A);
    chk("hold_busy", 32'(busy), 32'h1);
    hold = 1'b0;
    tick(1);
    chk("hold_release_prog", prog_num, 32'h0002_007F);
    chk("hold_release_update", 32'(update), 32'h1);
    chk("hold_release_busy", 32'(busy), 32'h0);

    // Reset mid-count on ch1 and mid-pulse on ch3
    tick(2);
    prog_in[31:24] = 8'h44;
    tick(7);
    prog_in[15:8] = 8'h22;
    tick(7);
    chk("pre_rst_prog", prog_num, 32'h4402_007F);
    chk("pre_rst_update", 32'(update), 32'h8);
    chk("pre_rst_busy", 32'(busy), 32'h2);
    rst_n = 1'b0;
    #1;
    chk("async_rst_prog", prog_num, 32'h0);
    chk("async_rst_update", 32'(update), 32'h0);
    chk("async_rst_busy", 32'(busy), 32'h0);
    chk("async_rst_glitch", glitch_cnt, 32'h0);
    chk("async_rst_prog_g", prog_num_g, 32'h0);
    prog_in = '0; prog_in_g = '0;
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // Glitch counter saturation on ch1, then clear
    for (int k = 0; k < 100; k++) begin
      prog_in[15:8] = 8'h01; tick(3);
      prog_in[15:8] = 8'h00; tick(3);
    end
    tick(5);
    chk("sat_count_100", glitch_cnt, 32'h0000_6400);
    for (int k = 0; k < 200; k++) begin
      prog_in[15:8] = 8'h01; tick(3);
      prog_in[15:8] = 8'h00; tick(3);
    end
    tick(5);
    chk("sat_count_255", glitch_cnt, 32'h0000_FF00);
    chk("sat_prog_kept", prog_num, 32'h0);
    glitch_clr = 1'b1;
    tick(1);
    glitch_clr = 1'b0;
    chk("glitch_clr", glitch_cnt, 32'h0);
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
